// File: rtl/reset_teardown_seq.sv
// Staged reset controller for the dual-camera PIP pipeline.
// Power-on: holds all four domain resets low, then releases them in order 0..3.
// Soft reset: tears the domains down 3..0, each on its quiesce ack or a timeout,
// then repeats the hold/release sequence. All outputs are registered.
module reset_teardown_seq #(
   parameter int unsigned     CW       = 22,
   parameter logic [CW-1:0]   HOLD_CYC = 22'h1FFFFF,
   parameter logic [CW-1:0]   STEP_CYC = 22'h100000,
   parameter logic [CW-1:0]   ACK_TO   = 22'h0FFFFF
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iREQ,
   input  logic [3:0] iACK,
   output logic [3:0] oRST,
   output logic       oBUSY,
   output logic       oDONE,
   output logic [3:0] oTMO
);

   // Terminal counts; every compare is equality so the counter never wraps.
   localparam logic [CW-1:0] HOLD_LAST = HOLD_CYC - CW'(1);
   localparam logic [CW-1:0] STEP_LAST = STEP_CYC - CW'(1);
   localparam logic [CW-1:0] ACK_LAST  = ACK_TO   - CW'(1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      idx_q;
   logic [3:0]      rst_q;
   logic            busy_q;
   logic            done_q;
   logic [3:0]      tmo_q;

   logic            hold_end;
   logic            step_end;
   logic            ack_hit;
   logic            ack_end;
   logic            drain_step;

   // Decode of the current stage's terminal conditions.
   always_comb begin
      hold_end   = (cnt_q == HOLD_LAST);
      step_end   = (cnt_q == STEP_LAST);
      ack_hit    = iACK[idx_q];
      ack_end    = (cnt_q == ACK_LAST);
      drain_step = ack_hit | ack_end;
   end

   // Sequencer: one stage changes per edge, outputs registered alongside the state.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= ST_HOLD;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         rst_q   <= 4'b0000;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         tmo_q   <= 4'b0000;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_HOLD: begin
               if (hold_end) begin
                  cnt_q   <= '0;
                  idx_q   <= 2'd0;
                  state_q <= ST_RELEASE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_RELEASE: begin
               if (step_end) begin
                  rst_q[idx_q] <= 1'b1;
                  cnt_q        <= '0;
                  if (idx_q == 2'd3) begin
                     state_q <= ST_RUN;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     idx_q <= idx_q + 2'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_RUN: begin
               cnt_q <= '0;
               if (iREQ) begin
                  state_q <= ST_DRAIN;
                  idx_q   <= 2'd3;
                  busy_q  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_step) begin
                  rst_q[idx_q] <= 1'b0;
                  cnt_q        <= '0;
                  // An ack arriving on the timeout edge still counts as a clean quiesce.
                  if (!ack_hit) tmo_q[idx_q] <= 1'b1;
                  if (idx_q == 2'd0) state_q <= ST_HOLD;
                  else               idx_q   <= idx_q - 2'd1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               state_q <= ST_HOLD;
               cnt_q   <= '0;
               idx_q   <= 2'd0;
               rst_q   <= 4'b0000;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign oRST  = rst_q;
   assign oBUSY = busy_q;
   assign oDONE = done_q;
   assign oTMO  = tmo_q;

endmodule
